// File: rtl/telemetry_rx_if.sv
// Telemetry receive bus: serial line in, decoded readings and status strobes out.
// Latency: none (wiring only).
// Backpressure: none; the strobes are fire-and-forget pulses.
interface telemetry_rx_if;
  logic        RX;
  logic [11:0] batt;
  logic [11:0] curr;
  logic [11:0] torque;
  logic        vld;
  logic        frm_err;
  logic        pkt_err;

  // Drives the serial line and observes the decoded results.
  modport master (
    output RX,
    input  batt, curr, torque, vld, frm_err, pkt_err
  );

  // The receiver: consumes the serial line, produces the decoded results.
  modport slave (
    input  RX,
    output batt, curr, torque, vld, frm_err, pkt_err
  );
endinterface

// File: rtl/telemetry_rx.sv
// 8N1 UART receiver plus framer for the 8-byte eBike telemetry packet (AA 55 bh bl ch cl th tl).
// Latency: vld rises 1 clk after the stop-bit sample of the last byte.
// Backpressure: none; results are held until the next good packet, strobes are single-cycle pulses.
module telemetry_rx #(
  parameter int BAUD_DIV = 5208,
  parameter int HALF_DIV = BAUD_DIV / 2
) (
  input  logic          clk,
  input  logic          rst_n,
  telemetry_rx_if.slave bus
);

  // Counter reload values: the counter runs down to zero, so N cycles means loading N-1.
  localparam logic [15:0] BAUD_LD = 16'(BAUD_DIV - 1);
  localparam logic [15:0] HALF_LD = 16'(HALF_DIV - 1);

  typedef enum logic [1:0] {
    B_IDLE,
    B_START,
    B_DATA,
    B_STOP
  } byte_state_t;

  typedef enum logic [2:0] {
    P_WAIT_AA,
    P_WAIT_55,
    P_BH,
    P_BL,
    P_CH,
    P_CL,
    P_TH,
    P_TL
  } pkt_state_t;

  // RX synchronizer and edge-detect history; idle level is high.
  logic rx_s1, rx_s2, rx_prev;

  // Byte deserializer state.
  byte_state_t bstate;
  logic [15:0] cnt;
  logic [3:0]  bit_cnt;
  logic [7:0]  shreg;
  logic        frm_err_q;

  // Packet framer state.
  pkt_state_t  pstate;
  logic [11:0] stage_b, stage_c;
  logic [3:0]  stage_t_hi;
  logic [11:0] batt_q, curr_q, torque_q;
  logic        vld_q, pkt_err_q;

  logic rx_fall;
  logic cnt_zero;
  logic stop_smp;
  logic byte_rdy;
  logic byte_bad;

  assign rx_fall  = rx_prev & ~rx_s2;
  assign cnt_zero = (cnt == 16'd0);
  // The stop-bit sample cycle: either completes a byte or flags a framing error.
  assign stop_smp = (bstate == B_STOP) && cnt_zero;
  assign byte_rdy = stop_smp && rx_s2;
  assign byte_bad = stop_smp && !rx_s2;

  // Two-flop synchronizer on RX plus one history flop for falling-edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_s1   <= 1'b1;
      rx_s2   <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_s1   <= bus.RX;
      rx_s2   <= rx_s1;
      rx_prev <= rx_s2;
    end
  end

  // Byte FSM: start detect, mid-bit sampling of 8 data bits LSB first, stop-bit check.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bstate    <= B_IDLE;
      cnt       <= 16'd0;
      bit_cnt   <= 4'd0;
      shreg     <= 8'd0;
      frm_err_q <= 1'b0;
    end else begin
      frm_err_q <= byte_bad;
      case (bstate)
        B_IDLE: begin
          if (rx_fall) begin
            cnt    <= HALF_LD;
            bstate <= B_START;
          end
        end
        B_START: begin
          if (cnt_zero) begin
            if (!rx_s2) begin
              cnt     <= BAUD_LD;
              bit_cnt <= 4'd0;
              bstate  <= B_DATA;
            end else begin
              // Line was high again at mid start bit: a glitch, not a frame.
              bstate <= B_IDLE;
            end
          end else begin
            cnt <= cnt - 16'd1;
          end
        end
        B_DATA: begin
          if (cnt_zero) begin
            shreg   <= {rx_s2, shreg[7:1]};
            cnt     <= BAUD_LD;
            bit_cnt <= bit_cnt + 4'd1;
            if (bit_cnt == 4'd7) begin
              bstate <= B_STOP;
            end
          end else begin
            cnt <= cnt - 16'd1;
          end
        end
        B_STOP: begin
          // Back to idle right at the stop sample so a start edge half a bit later is caught.
          if (cnt_zero) begin
            bstate <= B_IDLE;
          end else begin
            cnt <= cnt - 16'd1;
          end
        end
        default: bstate <= B_IDLE;
      endcase
    end
  end

  // Packet FSM: sync on AA 55, collect three 12-bit readings, commit them together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pstate     <= P_WAIT_AA;
      stage_b    <= 12'd0;
      stage_c    <= 12'd0;
      stage_t_hi <= 4'd0;
      batt_q     <= 12'd0;
      curr_q     <= 12'd0;
      torque_q   <= 12'd0;
      vld_q      <= 1'b0;
      pkt_err_q  <= 1'b0;
    end else begin
      vld_q     <= 1'b0;
      pkt_err_q <= 1'b0;
      if (byte_bad) begin
        // A framing error anywhere abandons the packet; committed outputs stay put.
        pstate <= P_WAIT_AA;
      end else if (byte_rdy) begin
        case (pstate)
          P_WAIT_AA: begin
            if (shreg == 8'hAA) pstate <= P_WAIT_55;
          end
          P_WAIT_55: begin
            if (shreg == 8'h55)      pstate <= P_BH;
            else if (shreg != 8'hAA) pstate <= P_WAIT_AA;
          end
          P_BH: begin
            if (shreg[7:4] != 4'd0) begin
              pkt_err_q <= 1'b1;
              pstate    <= P_WAIT_AA;
            end else begin
              stage_b[11:8] <= shreg[3:0];
              pstate        <= P_BL;
            end
          end
          P_BL: begin
            stage_b[7:0] <= shreg;
            pstate       <= P_CH;
          end
          P_CH: begin
            if (shreg[7:4] != 4'd0) begin
              pkt_err_q <= 1'b1;
              pstate    <= P_WAIT_AA;
            end else begin
              stage_c[11:8] <= shreg[3:0];
              pstate        <= P_CL;
            end
          end
          P_CL: begin
            stage_c[7:0] <= shreg;
            pstate       <= P_TH;
          end
          P_TH: begin
            if (shreg[7:4] != 4'd0) begin
              pkt_err_q <= 1'b1;
              pstate    <= P_WAIT_AA;
            end else begin
              stage_t_hi <= shreg[3:0];
              pstate     <= P_TL;
            end
          end
          P_TL: begin
            // Final byte goes straight into torque so all three readings update in one edge.
            batt_q   <= stage_b;
            curr_q   <= stage_c;
            torque_q <= {stage_t_hi, shreg};
            vld_q    <= 1'b1;
            pstate   <= P_WAIT_AA;
          end
          default: pstate <= P_WAIT_AA;
        endcase
      end
    end
  end

  assign bus.batt    = batt_q;
  assign bus.curr    = curr_q;
  assign bus.torque  = torque_q;
  assign bus.vld     = vld_q;
  assign bus.frm_err = frm_err_q;
  assign bus.pkt_err = pkt_err_q;

endmodule

// File: tb/tb_telemetry_rx.sv
// Scoreboard bench for telemetry_rx: directed packets in, expected strobes/readings queued.
// Latency: results checked whenever the DUT pulses vld/frm_err/pkt_err.
// Backpressure: none; the monitor consumes every pulse as it appears.
module tb_telemetry_rx;

  localparam int BAUD = 32;

  typedef struct {
    int          kind;  // 0 = vld, 1 = frm_err, 2 = pkt_err
    logic [11:0] b;
    logic [11:0] c;
    logic [11:0] t;
  } exp_t;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;
  exp_t exp_q[$];
  logic [7:0] txq[$];

  telemetry_rx_if bus ();

  telemetry_rx #(.BAUD_DIV(BAUD)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic push_exp(input int kind, input logic [11:0] b, input logic [11:0] c,
                          input logic [11:0] t);
    exp_t e;
    e.kind = kind;
    e.b    = b;
    e.c    = c;
    e.t    = t;
    exp_q.push_back(e);
  endtask

  task automatic check_val(input string name, input logic [11:0] act, input logic [11:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    bus.RX = 1'b0;
    repeat (BAUD) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      bus.RX = b[i];
      repeat (BAUD) @(negedge clk);
    end
    bus.RX = stop_bit;
    repeat (BAUD) @(negedge clk);
  endtask

  task automatic send_txq();
    for (int i = 0; i < txq.size(); i++) begin
      send_byte(txq[i], 1'b1);
    end
  endtask

  task automatic idle_bits(input int n);
    bus.RX = 1'b1;
    repeat (n * BAUD) @(negedge clk);
  endtask

  // Monitor: every strobe pops one expectation and compares kind and held readings.
  initial begin
    exp_t e;
    int   n;
    int   kind;
    forever begin
      @(negedge clk);
      n = int'(bus.vld) + int'(bus.frm_err) + int'(bus.pkt_err);
      if (n > 0) begin
        checks++;
        kind = bus.vld ? 0 : (bus.frm_err ? 1 : 2);
        if (n > 1) begin
          errors++;
          $display("FAIL exclusive: vld=%b frm_err=%b pkt_err=%b, required at most one",
                   bus.vld, bus.frm_err, bus.pkt_err);
        end else if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected: strobe kind %0d with nothing expected", kind);
        end else begin
          e = exp_q.pop_front();
          if (kind != e.kind || bus.batt !== e.b || bus.curr !== e.c || bus.torque !== e.t) begin
            errors++;
            $display("FAIL event: got kind %0d b=%h c=%h t=%h expected kind %0d b=%h c=%h t=%h",
                     kind, bus.batt, bus.curr, bus.torque, e.kind, e.b, e.c, e.t);
          end
        end
      end
    end
  end

  initial begin
    checks = 0;
    errors = 0;
    bus.RX = 1'b1;
    rst_n  = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    check_val("reset_batt", bus.batt, 12'h000);
    check_val("reset_curr", bus.curr, 12'h000);
    check_val("reset_torque", bus.torque, 12'h000);
    check_val("reset_vld", 12'(bus.vld), 12'h0);
    check_val("reset_frm_err", 12'(bus.frm_err), 12'h0);
    check_val("reset_pkt_err", 12'(bus.pkt_err), 12'h0);
    idle_bits(2);

    // Basic packet.
    push_exp(0, 12'hABC, 12'h123, 12'h7FF);
    txq = '{8'hAA, 8'h55, 8'h0A, 8'hBC, 8'h01, 8'h23, 8'h07, 8'hFF};
    send_txq();
    idle_bits(2);

    // Two packets back to back with no idle between them.
    push_exp(0, 12'h111, 12'h222, 12'h333);
    push_exp(0, 12'h000, 12'hFFF, 12'h800);
    txq = '{8'hAA, 8'h55, 8'h01, 8'h11, 8'h02, 8'h22, 8'h03, 8'h33,
            8'hAA, 8'h55, 8'h00, 8'h00, 8'h0F, 8'hFF, 8'h08, 8'h00};
    send_txq();
    idle_bits(2);

    // Leading junk and a repeated AA before the sync word.
    push_exp(0, 12'h100, 12'h200, 12'h300);
    txq = '{8'h12, 8'hAA, 8'hAA, 8'h55, 8'h01, 8'h00, 8'h02, 8'h00, 8'h03, 8'h00};
    send_txq();
    idle_bits(2);

    // Bad high nibble in batt_hi, then a good packet.
    push_exp(2, 12'h100, 12'h200, 12'h300);
    txq = '{8'hAA, 8'h55, 8'h1A};
    send_txq();
    idle_bits(2);
    push_exp(0, 12'h456, 12'h078, 12'h99A);
    txq = '{8'hAA, 8'h55, 8'h04, 8'h56, 8'h00, 8'h78, 8'h09, 8'h9A};
    send_txq();
    idle_bits(2);

    // Stop bit low inside curr_lo.
    push_exp(1, 12'h456, 12'h078, 12'h99A);
    txq = '{8'hAA, 8'h55, 8'h0A, 8'hBC, 8'h01};
    send_txq();
    send_byte(8'h23, 1'b0);
    idle_bits(2);

    // Quarter-bit glitch on an idle line: no byte, no error.
    bus.RX = 1'b0;
    repeat (BAUD / 4) @(negedge clk);
    idle_bits(3);

    push_exp(0, 12'h011, 12'h022, 12'h033);
    txq = '{8'hAA, 8'h55, 8'h00, 8'h11, 8'h00, 8'h22, 8'h00, 8'h33};
    send_txq();
    idle_bits(2);

    // Reset in the middle of torque_lo.
    txq = '{8'hAA, 8'h55, 8'h0C, 8'hCC, 8'h0D, 8'hDD, 8'h0E};
    send_txq();
    bus.RX = 1'b0;
    repeat (BAUD * 4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_val("rst_mid_batt", bus.batt, 12'h000);
    check_val("rst_mid_curr", bus.curr, 12'h000);
    check_val("rst_mid_torque", bus.torque, 12'h000);
    check_val("rst_mid_vld", 12'(bus.vld), 12'h0);
    repeat (3) @(negedge clk);
    bus.RX = 1'b1;
    rst_n  = 1'b1;
    idle_bits(2);
    push_exp(0, 12'hF0F, 12'h101, 12'hA0A);
    txq = '{8'hAA, 8'h55, 8'h0F, 8'h0F, 8'h01, 8'h01, 8'h0A, 8'h0A};
    send_txq();

    // Drain: every expected strobe must have appeared within the budget.
    for (int i = 0; i < 2000 && exp_q.size() != 0; i++) begin
      @(negedge clk);
    end
    repeat (4) @(negedge clk);
    check_val("pending_expectations", 12'(exp_q.size()), 12'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
